axi4_read_arbiter: RTL and testbench

Shares one AXI4 read channel (AR plus R) among NUM_REQ requesters. Arbitration is round-robin, and the grant is held until the last read-data beat of the granted burst. Only one burst is outstanding at a time. The block sits between the requester-side read ports and the single downstream AXI4ReadChannel of the AXI4 bundle. It provides the sequencing that the bundle itself lacks.

---
 rtl/axi4_arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/axi4_read_arbiter.sv | 138 +++++++++++++
 tb/tb_axi4_read_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_arb_pkg.sv
// Shared types for the AXI4 read-channel arbiter: FSM states and AXI response codes.
package axi4_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  typedef logic [1:0] resp_t;

  localparam resp_t OKAY   = 2'b00;
  localparam resp_t EXOKAY = 2'b01;
  localparam resp_t SLVERR = 2'b10;
  localparam resp_t DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] gnt,
  output logic                       vld
);

  localparam int GW = $clog2(NUM_REQ);

  logic [GW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest request overwrites the rest.
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = GW'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        gnt = idx;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel among NUM_REQ requesters, one burst at a time.
// Optional rlast/beat-count checking is enabled by defining AXI4_RD_ARB_LAST_CHECK_EN.
module axi4_read_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [NUM_REQ-1:0]           req_arvalid,
  output logic [NUM_REQ-1:0]           req_arready,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_araddr,
  input  logic [NUM_REQ*LEN_W-1:0]     req_arlen,
  output logic [NUM_REQ-1:0]           req_rvalid,
  input  logic [NUM_REQ-1:0]           req_rready,
  output logic [DATA_W-1:0]            req_rdata,
  output resp_t                        req_rresp,
  output logic                         req_rlast,
  output logic                         m_arvalid,
  input  logic                         m_arready,
  output logic [ADDR_W-1:0]            m_araddr,
  output logic [LEN_W-1:0]             m_arlen,
  input  logic                         m_rvalid,
  output logic                         m_rready,
  input  logic [DATA_W-1:0]            m_rdata,
  input  resp_t                        m_rresp,
  input  logic                         m_rlast,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         err_last
);

  localparam int GW = $clog2(NUM_REQ);

  state_t        state;
  logic [GW-1:0] grant;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] pick;
  logic          pick_vld;
  logic          ar_hs;
  logic          r_hs;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req(req_arvalid),
    .ptr(rr_ptr),
    .gnt(pick),
    .vld(pick_vld)
  );

  // Address fields stay valid on the requester side, so they are muxed rather than captured.
  assign m_araddr  = req_araddr[grant*ADDR_W +: ADDR_W];
  assign m_arlen   = req_arlen[grant*LEN_W +: LEN_W];
  assign req_rdata = m_rdata;
  assign req_rresp = m_rresp;
  assign req_rlast = m_rlast;
  assign grant_id  = grant;
  assign ar_hs     = m_arvalid & m_arready;
  assign r_hs      = m_rvalid & m_rready;

  always_comb begin
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    req_arready = '0;
    req_rvalid  = '0;
    case (state)
      ADDR: begin
        m_arvalid          = req_arvalid[grant];
        req_arready[grant] = m_arready;
      end
      DATA: begin
        m_rready          = req_rready[grant];
        req_rvalid[grant] = m_rvalid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= pick;
            state <= ADDR;
            busy  <= 1'b1;
          end
        end
        ADDR: begin
          if (ar_hs) state <= DATA;
        end
        DATA: begin
          // The slave's rlast alone ends the burst; the pointer moves past the served requester.
          if (r_hs && m_rlast) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + GW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXI4_RD_ARB_LAST_CHECK_EN
  logic [LEN_W-1:0] beat_cnt;

  // beat_cnt counts the beats still owed after the current one; it never steers the FSM.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      beat_cnt <= '0;
      err_last <= 1'b0;
    end else begin
      err_last <= 1'b0;
      if (state == ADDR && ar_hs) beat_cnt <= m_arlen;
      if (state == DATA && r_hs) begin
        err_last <= m_rlast ? (beat_cnt != '0) : (beat_cnt == '0);
        if (beat_cnt != '0) beat_cnt <= beat_cnt - LEN_W'(1);
      end
    end
  end
`else
  assign err_last = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_read_arbiter.sv
// Bench for axi4_read_arbiter: directed scenarios plus randomized traffic against a round-robin model.
module tb_axi4_read_arbiter;
  import axi4_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int GW = $clog2(N);

  logic            aclk = 1'b0;
  logic            areset = 1'b1;
  logic [N-1:0]    req_arvalid = '0;
  logic [N-1:0]    req_arready;
  logic [N*AW-1:0] req_araddr = '0;
  logic [N*LW-1:0] req_arlen = '0;
  logic [N-1:0]    req_rvalid;
  logic [N-1:0]    req_rready = '0;
  logic [DW-1:0]   req_rdata;
  resp_t           req_rresp;
  logic            req_rlast;
  logic            m_arvalid;
  logic            m_arready = 1'b0;
  logic [AW-1:0]   m_araddr;
  logic [LW-1:0]   m_arlen;
  logic            m_rvalid = 1'b0;
  logic            m_rready;
  logic [DW-1:0]   m_rdata = '0;
  resp_t           m_rresp = OKAY;
  logic            m_rlast = 1'b0;
  logic [GW-1:0]   grant_id;
  logic            busy;
  logic            err_last;

  axi4_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .aclk(aclk), .areset(areset),
    .req_arvalid(req_arvalid), .req_arready(req_arready), .req_araddr(req_araddr),
    .req_arlen(req_arlen), .req_rvalid(req_rvalid), .req_rready(req_rready),
    .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rlast(req_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .grant_id(grant_id), .busy(busy), .err_last(err_last)
  );

  always #5 aclk = ~aclk;

  typedef struct packed { logic [AW-1:0] addr; logic [LW-1:0] len; } burst_t;
  typedef struct packed { logic [DW-1:0] data; resp_t resp; logic last; } beat_t;

  burst_t pend [N][$];
  beat_t  rx   [N][$];
  int     ar_q[$], ar_cyc[$], last_cyc[$];
  int     ev_ar, ev_r;
  burst_t ev_burst;
  beat_t  ev_beat;
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  int     rready_pct = 100;
  logic [N-1:0] force_low = '0;
  int     slv_ar_pct = 100;
  int     slv_r_pct = 100;
  bit     slv_bad_last = 1'b0;

  function automatic resp_t exp_resp(logic [AW-1:0] a);
    return a[4] ? SLVERR : OKAY;
  endfunction

  // Downstream slave: one burst at a time, data = addr + beat index, response from addr bit 4.
  initial begin
    bit arf, rf, s_act;
    logic [AW-1:0] na, s_addr;
    int nl, s_last, s_beat;
    s_act = 0; s_addr = '0; s_last = 0; s_beat = 0; na = '0; nl = 0;
    forever begin
      @(negedge aclk);
      arf = m_arvalid && m_arready;
      rf  = m_rvalid && m_rready;
      if (arf) begin na = m_araddr; nl = int'(m_arlen); end
      @(posedge aclk); #1;
      if (areset) begin
        s_act = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0;
      end else begin
        if (arf) begin s_act = 1; s_addr = na; s_last = slv_bad_last ? 0 : nl; s_beat = 0; end
        if (rf) begin
          if (s_beat == s_last) s_act = 0;
          s_beat++;
        end
        m_arready = !s_act && (int'($urandom_range(99)) < slv_ar_pct);
        if (!s_act) m_rvalid = 0;
        else if (!(m_rvalid && !rf)) m_rvalid = int'($urandom_range(99)) < slv_r_pct;
        m_rdata = s_addr + DW'(s_beat);
        m_rresp = exp_resp(s_addr);
        m_rlast = s_act && (s_beat == s_last);
      end
    end
  end

  // One clock: drive requesters after the edge, then capture handshakes on the falling edge.
  task automatic step();
    @(posedge aclk); #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (pend[i].size() > 0) begin
        req_arvalid[i] = 1'b1;
        req_araddr[i*AW +: AW] = pend[i][0].addr;
        req_arlen[i*LW +: LW]  = pend[i][0].len;
      end else begin
        req_arvalid[i] = 1'b0;
      end
      req_rready[i] = !force_low[i] && (int'($urandom_range(99)) < rready_pct);
    end
    @(negedge aclk);
    ev_ar = -1;
    ev_r  = -1;
    for (int i = 0; i < N; i++) begin
      if (req_arvalid[i] && req_arready[i]) begin
        ev_ar = i;
        ev_burst = pend[i].pop_front();
        ar_q.push_back(i);
        ar_cyc.push_back(cyc);
      end
      if (req_rvalid[i] && req_rready[i]) begin
        ev_r = i;
        ev_beat.data = req_rdata;
        ev_beat.resp = req_rresp;
        ev_beat.last = req_rlast;
        rx[i].push_back(ev_beat);
        if (req_rlast) last_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < N; i++) rx[i].delete();
    ar_q.delete(); ar_cyc.delete(); last_cyc.delete();
    force_low = '0;
  endtask

  task automatic do_reset();
    @(posedge aclk); #1;
    areset = 1'b1;
    for (int i = 0; i < N; i++) pend[i].delete();
    req_arvalid = '0;
    @(posedge aclk); #3;
    areset = 1'b0;
    @(negedge aclk);
  endtask

  task automatic test_reset();
    req_arvalid = '1;
    req_rready  = '1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL rst_m_arvalid: got %0h expected 0", m_arvalid); end
    checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL rst_m_rready: got %0h expected 0", m_rready); end
    checks++; if (req_arready !== '0) begin errors++; $display("FAIL rst_req_arready: got %0h expected 0", req_arready); end
    checks++; if (req_rvalid !== '0) begin errors++; $display("FAIL rst_req_rvalid: got %0h expected 0", req_rvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0h expected 0", busy); end
    checks++; if (grant_id !== '0) begin errors++; $display("FAIL rst_grant_id: got %0h expected 0", grant_id); end
    checks++; if (err_last !== 1'b0) begin errors++; $display("FAIL rst_err_last: got %0h expected 0", err_last); end
    @(posedge aclk); #3;
    areset = 1'b0;
    req_arvalid = '0;
    req_rready = '0;
    @(negedge aclk);
  endtask

  task automatic test_single();
    clear_logs();
    pend[0].push_back('{32'h1000, 8'd3});
    step();
    checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL single_c0_arvalid: got %0h expected 0", m_arvalid); end
    step();
    checks++; if (m_arvalid !== 1'b1) begin errors++; $display("FAIL single_c1_arvalid: got %0h expected 1", m_arvalid); end
    checks++; if (m_araddr !== 32'h1000) begin errors++; $display("FAIL single_araddr: got %0h expected 1000", m_araddr); end
    checks++; if (m_arlen !== 8'd3) begin errors++; $display("FAIL single_arlen: got %0h expected 3", m_arlen); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0h expected 1", busy); end
    for (int n = 0; n < 100 && last_cyc.size() < 1; n++) step();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %0h expected 0", busy); end
    checks++; if (rx[0].size() !== 4) begin errors++; $display("FAIL single_beats: got %0d expected 4", rx[0].size()); end
    checks++; if (rx[1].size() + rx[2].size() !== 0) begin errors++; $display("FAIL single_other_beats: got %0d expected 0", rx[1].size() + rx[2].size()); end
    for (int k = 0; k < rx[0].size(); k++) begin
      checks++; if (rx[0][k].data !== 32'h1000 + k) begin errors++; $display("FAIL single_data%0d: got %0h expected %0h", k, rx[0][k].data, 32'h1000 + k); end
      checks++; if (rx[0][k].last !== (k == 3)) begin errors++; $display("FAIL single_last%0d: got %0h expected %0h", k, rx[0][k].last, (k == 3)); end
    end
  endtask

  task automatic test_contention();
    do_reset();
    clear_logs();
    pend[0].push_back('{32'h2000, 8'd2});
    pend[1].push_back('{32'h3010, 8'd1});
    for (int n = 0; n < 200 && last_cyc.size() < 2; n++) step();
    checks++; if (ar_q.size() !== 2) begin errors++; $display("FAIL cont_grants: got %0d expected 2", ar_q.size()); end
    if (ar_q.size() >= 2 && last_cyc.size() >= 2) begin
      checks++; if (ar_q[0] !== 0 || ar_q[1] !== 1) begin errors++; $display("FAIL cont_order: got %0d,%0d expected 0,1", ar_q[0], ar_q[1]); end
      checks++; if (ar_cyc[1] - last_cyc[0] !== 2) begin errors++; $display("FAIL cont_gap: got %0d expected 2", ar_cyc[1] - last_cyc[0]); end
    end
    checks++; if (rx[1].size() !== 2) begin errors++; $display("FAIL cont_beats1: got %0d expected 2", rx[1].size()); end
    if (rx[1].size() == 2) begin
      checks++; if (rx[1][1].data !== 32'h3011 || rx[1][1].resp !== SLVERR) begin errors++; $display("FAIL cont_beat1: got %0h/%0h expected 3011/%0h", rx[1][1].data, rx[1][1].resp, SLVERR); end
    end
    // Both prior grants leave the pointer at 2, so a full three-way contention starts there.
    clear_logs();
    for (int i = 0; i < N; i++) pend[i].push_back('{32'h2100 + 32'(i * 'h100), 8'd0});
    for (int n = 0; n < 200 && last_cyc.size() < 3; n++) step();
    checks++; if (ar_q.size() !== 3) begin errors++; $display("FAIL cont3_grants: got %0d expected 3", ar_q.size()); end
    if (ar_q.size() == 3) begin
      checks++; if (ar_q[0] !== 2 || ar_q[1] !== 0 || ar_q[2] !== 1) begin errors++; $display("FAIL cont3_order: got %0d,%0d,%0d expected 2,0,1", ar_q[0], ar_q[1], ar_q[2]); end
    end
  endtask

  task automatic test_backpressure();
    clear_logs();
    pend[0].push_back('{32'h4000, 8'd5});
    for (int n = 0; n < 100 && rx[0].size() < 2; n++) step();
    force_low[0] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL bp_m_rready%0d: got %0h expected 0", n, m_rready); end
      checks++; if (req_rvalid[0] !== 1'b1) begin errors++; $display("FAIL bp_rvalid%0d: got %0h expected 1", n, req_rvalid[0]); end
    end
    checks++; if (rx[0].size() !== 2) begin errors++; $display("FAIL bp_stalled: got %0d expected 2", rx[0].size()); end
    force_low[0] = 1'b0;
    for (int n = 0; n < 100 && last_cyc.size() < 1; n++) step();
    checks++; if (rx[0].size() !== 6) begin errors++; $display("FAIL bp_beats: got %0d expected 6", rx[0].size()); end
    for (int k = 0; k < rx[0].size(); k++) begin
      checks++; if (rx[0][k].data !== 32'h4000 + k) begin errors++; $display("FAIL bp_data%0d: got %0h expected %0h", k, rx[0][k].data, 32'h4000 + k); end
    end
  endtask

  task automatic test_late_request();
    clear_logs();
    pend[0].push_back('{32'h5000, 8'd3});
    for (int n = 0; n < 100 && rx[0].size() < 1; n++) step();
    pend[1].push_back('{32'h6020, 8'd0});
    for (int n = 0; n < 100 && last_cyc.size() < 1; n++) begin
      step();
      checks++; if (req_arready[1] !== 1'b0) begin errors++; $display("FAIL late_early_ready: got %0h expected 0", req_arready[1]); end
    end
    step();
    checks++; if (m_arvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL late_idle_gap: got arvalid %0h busy %0h expected 0 0", m_arvalid, busy); end
    step();
    checks++; if (grant_id !== GW'(1)) begin errors++; $display("FAIL late_grant: got %0d expected 1", grant_id); end
    checks++; if (m_arvalid !== 1'b1 || req_arready[1] !== 1'b1) begin errors++; $display("FAIL late_ar: got arvalid %0h arready %0h expected 1 1", m_arvalid, req_arready[1]); end
    for (int n = 0; n < 100 && last_cyc.size() < 2; n++) step();
    checks++; if (rx[1].size() !== 1) begin errors++; $display("FAIL late_beats: got %0d expected 1", rx[1].size()); end
    if (rx[1].size() == 1) begin
      checks++; if (rx[1][0].data !== 32'h6020 || rx[1][0].last !== 1'b1) begin errors++; $display("FAIL late_beat: got %0h/%0h expected 6020/1", rx[1][0].data, rx[1][0].last); end
    end
  endtask

  task automatic test_mid_reset();
    clear_logs();
    pend[2].push_back('{32'h7000, 8'd7});
    for (int n = 0; n < 100 && rx[2].size() < 2; n++) step();
    #2 areset = 1'b1;
    #1;
    checks++; if (m_arvalid !== 1'b0 || m_rready !== 1'b0) begin errors++; $display("FAIL mrst_outputs: got arvalid %0h rready %0h expected 0 0", m_arvalid, m_rready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %0h expected 0", busy); end
    checks++; if (req_rvalid !== '0) begin errors++; $display("FAIL mrst_rvalid: got %0h expected 0", req_rvalid); end
    for (int i = 0; i < N; i++) pend[i].delete();
    @(posedge aclk); #3;
    areset = 1'b0;
    @(negedge aclk);
    // A pointer back at 0 favours requester 1 over 2; a stale pointer of 2 would not.
    clear_logs();
    pend[1].push_back('{32'h7100, 8'd0});
    pend[2].push_back('{32'h7200, 8'd0});
    for (int n = 0; n < 200 && last_cyc.size() < 2; n++) step();
    checks++; if (ar_q.size() !== 2) begin errors++; $display("FAIL mrst_grants: got %0d expected 2", ar_q.size()); end
    if (ar_q.size() == 2) begin
      checks++; if (ar_q[0] !== 1 || ar_q[1] !== 2) begin errors++; $display("FAIL mrst_ptr_order: got %0d,%0d expected 1,2", ar_q[0], ar_q[1]); end
    end
  endtask

  task automatic test_last_check();
    clear_logs();
    slv_bad_last = 1'b1;
    pend[0].push_back('{32'h8000, 8'd1});
    for (int n = 0; n < 100 && last_cyc.size() < 1; n++) step();
    checks++; if (err_last !== 1'b0) begin errors++; $display("FAIL err_before: got %0h expected 0", err_last); end
    step();
`ifdef AXI4_RD_ARB_LAST_CHECK_EN
    checks++; if (err_last !== 1'b1) begin errors++; $display("FAIL err_pulse: got %0h expected 1", err_last); end
`else
    checks++; if (err_last !== 1'b0) begin errors++; $display("FAIL err_tied: got %0h expected 0", err_last); end
`endif
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_idle: got %0h expected 0", busy); end
    step();
    checks++; if (err_last !== 1'b0) begin errors++; $display("FAIL err_clear: got %0h expected 0", err_last); end
    checks++; if (rx[0].size() !== 1) begin errors++; $display("FAIL err_beats: got %0d expected 1", rx[0].size()); end
    slv_bad_last = 1'b0;
  endtask

  task automatic test_random();
    int mptr, mgnt, cur_k, cur_len, left;
    bit midle;
    logic [AW-1:0] cur_addr;
    int exp_beats [N];
    burst_t b;
    do_reset();
    clear_logs();
    mptr = 0; mgnt = 0; midle = 1'b1; cur_k = 0; cur_len = 0; cur_addr = '0;
    for (int i = 0; i < N; i++) exp_beats[i] = 0;
    slv_ar_pct = 70; slv_r_pct = 70; rready_pct = 70;
    for (int c = 0; c < 4000; c++) begin
      left = 0;
      for (int i = 0; i < N; i++) left += pend[i].size();
      if (c >= 1200 && midle && left == 0) break;
      if (c < 1200) begin
        for (int i = 0; i < N; i++) begin
          if (pend[i].size() < 2 && $urandom_range(99) < 8) begin
            b.addr = $urandom;
            b.len  = LW'($urandom_range(7));
            pend[i].push_back(b);
            exp_beats[i] += int'(b.len) + 1;
          end
        end
      end
      step();
      checks++; if (busy !== !midle) begin errors++; $display("FAIL rnd_busy c%0d: got %0h expected %0h", cyc, busy, !midle); end
      checks++; if (err_last !== 1'b0) begin errors++; $display("FAIL rnd_err c%0d: got %0h expected 0", cyc, err_last); end
      if (ev_ar >= 0) begin
        checks++; if (ev_ar !== mgnt || midle) begin errors++; $display("FAIL rnd_grant c%0d: got %0d expected %0d", cyc, ev_ar, mgnt); end
        checks++; if (m_araddr !== ev_burst.addr) begin errors++; $display("FAIL rnd_araddr c%0d: got %0h expected %0h", cyc, m_araddr, ev_burst.addr); end
        cur_addr = ev_burst.addr; cur_len = int'(ev_burst.len); cur_k = 0;
      end
      if (ev_r >= 0) begin
        checks++; if (ev_r !== mgnt) begin errors++; $display("FAIL rnd_rowner c%0d: got %0d expected %0d", cyc, ev_r, mgnt); end
        checks++; if (ev_beat.data !== cur_addr + DW'(cur_k)) begin errors++; $display("FAIL rnd_data c%0d: got %0h expected %0h", cyc, ev_beat.data, cur_addr + DW'(cur_k)); end
        checks++; if (ev_beat.resp !== exp_resp(cur_addr)) begin errors++; $display("FAIL rnd_resp c%0d: got %0h expected %0h", cyc, ev_beat.resp, exp_resp(cur_addr)); end
        checks++; if (ev_beat.last !== (cur_k == cur_len)) begin errors++; $display("FAIL rnd_last c%0d: got %0h expected %0h", cyc, ev_beat.last, (cur_k == cur_len)); end
        cur_k++;
      end
      // Reference: an idle arbiter serves the first waiting requester at or after the pointer.
      if (midle) begin
        for (int k = N - 1; k >= 0; k--) begin
          if (req_arvalid[(mptr + k) % N]) begin mgnt = (mptr + k) % N; midle = 1'b0; end
        end
      end else if (ev_r >= 0 && ev_beat.last) begin
        midle = 1'b1;
        mptr = (mgnt + 1) % N;
      end
    end
    checks++; if (!midle) begin errors++; $display("FAIL rnd_drain: got busy model %0h expected idle", !midle); end
    for (int i = 0; i < N; i++) begin
      checks++; if (rx[i].size() !== exp_beats[i]) begin errors++; $display("FAIL rnd_count%0d: got %0d expected %0d", i, rx[i].size(), exp_beats[i]); end
    end
    slv_ar_pct = 100; slv_r_pct = 100; rready_pct = 100;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_late_request();
    test_mid_reset();
    test_last_check();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
